// File: rtl/score_multiplier.sv
// Shift-and-add multiplier: two 6-bit operands times a constant FACTOR, processed in parallel.
// One bit per cycle; results and a done pulse appear 6 cycles after start is accepted in IDLE.
module score_multiplier #(
  parameter logic [6:0] FACTOR = 7'd101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  time_multiplier,
  input  logic [5:0]  discovered_pairs_multiplier,
  output logic [12:0] mult_time_result,
  output logic [12:0] mult_discovered_pairs_result,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, MULT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [5:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [12:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [12:0] res_a_q, res_a_d, res_b_q, res_b_d;
  logic        done_q, done_d;

  logic [12:0] factor_ext;
  logic [12:0] addend;
  logic [5:0]  sh_a, sh_b;
  logic [12:0] sum_a, sum_b;

  // Partial product for the current bit; the shift keeps the index within the 6-bit operand.
  assign factor_ext = {6'd0, FACTOR};
  assign addend     = factor_ext << cnt_q;
  assign sh_a       = op_a_q >> cnt_q;
  assign sh_b       = op_b_q >> cnt_q;
  assign sum_a      = sh_a[0] ? (acc_a_q + addend) : acc_a_q;
  assign sum_b      = sh_b[0] ? (acc_b_q + addend) : acc_b_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    acc_a_d = acc_a_q;
    acc_b_d = acc_b_q;
    res_a_d = res_a_q;
    res_b_d = res_b_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d  = time_multiplier;
          op_b_d  = discovered_pairs_multiplier;
          acc_a_d = '0;
          acc_b_d = '0;
          cnt_d   = '0;
          state_d = MULT;
        end
      end
      MULT: begin
        acc_a_d = sum_a;
        acc_b_d = sum_b;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          res_a_d = sum_a;
          res_b_d = sum_b;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_a_q <= '0;
      acc_b_q <= '0;
      res_a_q <= '0;
      res_b_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      acc_a_q <= acc_a_d;
      acc_b_q <= acc_b_d;
      res_a_q <= res_a_d;
      res_b_q <= res_b_d;
      done_q  <= done_d;
    end
  end

  assign mult_time_result             = res_a_q;
  assign mult_discovered_pairs_result = res_b_q;
  assign busy                         = (state_q == MULT);
  assign done                         = done_q;

endmodule

// File: tb/tb_score_multiplier.sv
// Directed bench for score_multiplier: vector table plus reset, overlap and back-to-back sequences.
module tb_score_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  a, b;
  logic [12:0] res_t, res_p;
  logic        busy, done;

  int n_checks;
  int n_pass;

  score_multiplier #(.FACTOR(7'd101)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .start                        (start),
    .time_multiplier              (a),
    .discovered_pairs_multiplier  (b),
    .mult_time_result             (res_t),
    .mult_discovered_pairs_result (res_p),
    .busy                         (busy),
    .done                         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  a;
    logic [5:0]  b;
    logic [12:0] exp_t;
    logic [12:0] exp_p;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One full operation: start pulse, scramble operands after capture, check busy/done per cycle.
  task automatic run_op(input logic [5:0] va, input logic [5:0] vb,
                        input logic [12:0] et, input logic [12:0] ep);
    @(negedge clk);
    start = 1'b1; a = va; b = vb;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 6'($urandom);
    b = 6'($urandom);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("busy_during_op", busy, 1);
      check("no_early_done", done, 0);
    end
    @(negedge clk);
    check("busy_after_op", busy, 0);
    check("done_pulse", done, 1);
    check("time_result", res_t, et);
    check("pairs_result", res_p, ep);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("time_result_hold", res_t, et);
    check("pairs_result_hold", res_p, ep);
  endtask

  initial begin
    int done_cnt;
    int last_done;
    int gaps_ok;

    n_checks = 0;
    n_pass   = 0;
    vecs[0] = '{6'd33, 6'd0,  13'd3333, 13'd0};
    vecs[1] = '{6'd63, 6'd1,  13'd6363, 13'd101};
    vecs[2] = '{6'd5,  6'd32, 13'd505,  13'd3232};
    vecs[3] = '{6'd0,  6'd0,  13'd0,    13'd0};
    vecs[4] = '{6'd63, 6'd63, 13'd6363, 13'd6363};
    vecs[5] = '{6'd1,  6'd2,  13'd101,  13'd202};

    rst = 1'b0; start = 1'b0; a = '0; b = '0;

    // Reset held low: clock and inputs must have no effect.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'($urandom); a = 6'($urandom); b = 6'($urandom);
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_res", {19'd0, res_t}, 0);
      check("rst_res_p", {19'd0, res_p}, 0);
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp_t, vecs[i].exp_p);

    // Operand change and second start while busy are ignored.
    @(negedge clk);
    start = 1'b1; a = 6'd10; b = 6'd2;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a = 6'd20; b = 6'd4;
    @(posedge clk); #1; start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check("ovl_time", res_t, 1010);
        check("ovl_pairs", res_p, 202);
      end
    end
    check("ovl_single_done", done_cnt, 1);

    // Reset mid-operation aborts without done and clears results.
    @(negedge clk);
    start = 1'b1; a = 6'd33; b = 6'd33;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_res_t", res_t, 0);
    check("abort_res_p", res_p, 0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    rst = 1'b1;
    run_op(6'd1, 6'd2, 13'd101, 13'd202);

    // start held high: done every 7th cycle, results constant.
    @(negedge clk);
    start = 1'b1; a = 6'd7; b = 6'd3;
    done_cnt = 0; last_done = -1; gaps_ok = 1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (last_done >= 0 && (i - last_done) != 7) gaps_ok = 0;
        last_done = i;
        done_cnt++;
        check("b2b_time", res_t, 707);
        check("b2b_pairs", res_p, 303);
      end
    end
    start = 1'b0;
    check("b2b_spacing", gaps_ok, 1);
    check("b2b_count", done_cnt, 4);
    repeat (8) @(negedge clk);
    check("b2b_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
